// File: rtl/pipe_pkg.sv
// Shared types and constants for the inter-stage pipeline register.
// Bubbles are all-zero payloads so downstream decodes them as nop.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    localparam logic [31:0]   DEFAULT_RESET_PC = 32'h3000;
    localparam int            EXC_NONE         = 0;
    // Wide enough for any payload; users slice it to DATA_W.
    localparam logic [1023:0] NOP_DATA         = '0;

endpackage

// File: rtl/pipe_slot.sv
// One holding entry of the pipeline register: payload, pc, exception, delay-slot flag, valid.
// Priority is flush > load > clear; clear keeps pc so the bubble reports the last delivered pc.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int          DATA_W   = 128,
    parameter int          PC_W     = 32,
    parameter int          EXC_W    = 5,
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC[PC_W-1:0]
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic              flush,
    input  logic [PC_W-1:0]   flush_pc,
    input  logic [DATA_W-1:0] d_data,
    input  logic [PC_W-1:0]   d_pc,
    input  logic [EXC_W-1:0]  d_exc,
    input  logic              d_bd,
    output logic              q_valid,
    output logic [DATA_W-1:0] q_data,
    output logic [PC_W-1:0]   q_pc,
    output logic [EXC_W-1:0]  q_exc,
    output logic              q_bd
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_valid <= 1'b0;
            q_data  <= NOP_DATA[DATA_W-1:0];
            q_pc    <= RESET_PC;
            q_exc   <= EXC_W'(EXC_NONE);
            q_bd    <= 1'b0;
        end else if (flush) begin
            q_valid <= 1'b0;
            q_data  <= NOP_DATA[DATA_W-1:0];
            q_pc    <= flush_pc;
            q_exc   <= EXC_W'(EXC_NONE);
            q_bd    <= 1'b0;
        end else if (load) begin
            q_valid <= 1'b1;
            q_data  <= d_data;
            q_pc    <= d_pc;
            q_exc   <= d_exc;
            q_bd    <= d_bd;
        end else if (clear) begin
            q_valid <= 1'b0;
            q_data  <= NOP_DATA[DATA_W-1:0];
            q_exc   <= EXC_W'(EXC_NONE);
            q_bd    <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid slot,
// synchronous flush with bubble insertion and a saturating back-pressure counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int              DATA_W   = 128,
    parameter int              PC_W     = 32,
    parameter int              EXC_W    = 5,
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC[PC_W-1:0],
    parameter bit              SKID_EN  = 1'b1,
    parameter int              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              in_bd,
    input  logic              flush,
    input  logic [PC_W-1:0]   flush_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_bd,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_e state_q, state_d;

    logic              acc;
    logic              main_load, main_clear, main_from_skid;
    logic              skid_load, skid_clear;
    logic              main_valid;
    logic [DATA_W-1:0] main_d_data;
    logic [PC_W-1:0]   main_d_pc;
    logic [EXC_W-1:0]  main_d_exc;
    logic              main_d_bd;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [PC_W-1:0]   skid_pc;
    logic [EXC_W-1:0]  skid_exc;
    logic              skid_bd;

    // With a skid slot, in_ready comes straight from a flop (skid empty == state!=SKID).
    assign in_ready = SKID_EN ? ~skid_valid : (~main_valid | out_ready);
    assign acc      = in_valid & in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (acc) state_d = ST_FULL;
                ST_FULL: begin
                    if (out_ready && !acc)           state_d = ST_EMPTY;
                    else if (!out_ready && acc && SKID_EN) state_d = ST_SKID;
                end
                ST_SKID:  if (out_ready) state_d = ST_FULL;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        case (state_q)
            ST_EMPTY: main_load = acc;
            ST_FULL: begin
                if (out_ready) begin
                    main_load  = acc;
                    main_clear = ~acc;
                end else begin
                    skid_load  = acc & SKID_EN;
                end
            end
            ST_SKID: begin
                main_load      = out_ready;
                main_from_skid = out_ready;
                skid_clear     = out_ready;
            end
            default: main_clear = 1'b1;
        endcase
    end

    // Skid beat always drains into main before any newer input.
    assign main_d_data = main_from_skid ? skid_data : in_data;
    assign main_d_pc   = main_from_skid ? skid_pc   : in_pc;
    assign main_d_exc  = main_from_skid ? skid_exc  : in_exc;
    assign main_d_bd   = main_from_skid ? skid_bd   : in_bd;

    pipe_slot #(
        .DATA_W(DATA_W), .PC_W(PC_W), .EXC_W(EXC_W), .RESET_PC(RESET_PC)
    ) u_main (
        .clk(clk), .reset(reset),
        .load(main_load), .clear(main_clear), .flush(flush), .flush_pc(flush_pc),
        .d_data(main_d_data), .d_pc(main_d_pc), .d_exc(main_d_exc), .d_bd(main_d_bd),
        .q_valid(main_valid), .q_data(out_data), .q_pc(out_pc), .q_exc(out_exc), .q_bd(out_bd)
    );

    generate
        if (SKID_EN) begin : g_skid
            pipe_slot #(
                .DATA_W(DATA_W), .PC_W(PC_W), .EXC_W(EXC_W), .RESET_PC(RESET_PC)
            ) u_skid (
                .clk(clk), .reset(reset),
                .load(skid_load), .clear(skid_clear), .flush(flush), .flush_pc(flush_pc),
                .d_data(in_data), .d_pc(in_pc), .d_exc(in_exc), .d_bd(in_bd),
                .q_valid(skid_valid), .q_data(skid_data), .q_pc(skid_pc),
                .q_exc(skid_exc), .q_bd(skid_bd)
            );
        end else begin : g_no_skid
            assign skid_valid = 1'b0;
            assign skid_data  = '0;
            assign skid_pc    = '0;
            assign skid_exc   = '0;
            assign skid_bd    = 1'b0;
        end
    endgenerate

    assign out_valid = main_valid;

    // Counts stalled cycles regardless of flush; sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule
